// File: rtl/intra_pkg.sv
// intra_pkg: shared intra mode indices, mode-decision FSM states and SAD width helper
package intra_pkg;
  localparam int MODE_V = 0;
  localparam int MODE_H = 1;
  localparam int MODE_DC = 2;
  localparam int MODE_PL = 3;
  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, ARGMIN, RESULT} state_t;
  function automatic int sad_width(input int res_w, input int npix);
    return res_w + $clog2(npix);
  endfunction
endpackage

// File: rtl/sad_lane_abs.sv
// sad_lane_abs: one mode's LANES-wide unsigned |res| sum (res: LANES signed residuals in, psum: lane abs-sum out)
module sad_lane_abs #(
  parameter int LANES = 4,
  parameter int RES_W = 9,
  parameter int PS_W = RES_W + $clog2(LANES)
) (
  input  logic [LANES-1:0][RES_W-1:0] res,
  output logic [PS_W-1:0]             psum
);
  logic [RES_W-1:0] a;
  always_comb begin
    psum = '0;
    a = '0;
    for (int l = 0; l < LANES; l++) begin
      a = res[l][RES_W-1] ? RES_W'(~res[l] + 1'b1) : res[l];
      psum = psum + PS_W'(a);
    end
  end
endmodule

// File: rtl/sad_stream_modesel.sv
// sad_stream_modesel: streaming per-mode SAD accumulator + masked argmin (start/mode_mask/res/in_valid in; in_ready, sads, best_mode, best_sad, none_valid, out_valid/out_ready, busy)
module sad_stream_modesel
  import intra_pkg::*;
#(
  parameter int NMODES = 4,
  parameter int NPIX = 64,
  parameter int LANES = 4,
  parameter int RES_W = 9,
  parameter int SAD_W = sad_width(RES_W, NPIX)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [NMODES-1:0]                           mode_mask,
  input  logic signed [NMODES-1:0][LANES-1:0][RES_W-1:0] res,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  output logic [NMODES-1:0][SAD_W-1:0]                sads,
  output logic [(NMODES > 1 ? $clog2(NMODES) : 1)-1:0] best_mode,
  output logic [SAD_W-1:0]                            best_sad,
  output logic                                        none_valid,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        busy
);
  localparam int MW = NMODES > 1 ? $clog2(NMODES) : 1;
  localparam int NB = NPIX / LANES;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  localparam int PS_W = RES_W + $clog2(LANES);
  state_t st;
  logic [CW-1:0] cnt;
  logic [NMODES-1:0] mask;
  logic [NMODES-1:0][PS_W-1:0] psum, psum_d;
  logic p_vld;
  logic [MW-1:0] am_mode;
  logic [SAD_W-1:0] am_sad;
  logic am_found;
  wire acc = in_valid && in_ready;
  for (genvar g = 0; g < NMODES; g++) begin : g_abs
    sad_lane_abs #(.LANES(LANES), .RES_W(RES_W), .PS_W(PS_W)) u_abs (
      .res (res[g]),
      .psum(psum_d[g])
    );
  end
  always_comb begin
    am_mode = '0;
    am_sad = '1;
    am_found = 1'b0;
    for (int m = 0; m < NMODES; m++)
      if (mask[m] && (!am_found || sads[m] < am_sad)) begin
        am_mode = MW'(m);
        am_sad = sads[m];
        am_found = 1'b1;
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      mask <= '0;
      psum <= '0;
      p_vld <= 1'b0;
      sads <= '0;
      best_mode <= '0;
      best_sad <= '0;
      none_valid <= 1'b0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      p_vld <= acc;
      if (acc) psum <= psum_d;
      if (p_vld)
        for (int m = 0; m < NMODES; m++) sads[m] <= sads[m] + SAD_W'(psum[m]);
      case (st)
        IDLE: if (start) begin
          st <= ACCUM;
          sads <= '0;
          cnt <= '0;
          p_vld <= 1'b0;
          mask <= mode_mask;
          in_ready <= 1'b1;
          busy <= 1'b1;
        end
        ACCUM: if (acc) begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NB - 1)) begin
            st <= DRAIN;
            cnt <= '0;
            in_ready <= 1'b0;
          end
        end
        DRAIN: st <= ARGMIN;
        ARGMIN: begin
          st <= RESULT;
          best_mode <= am_mode;
          best_sad <= am_sad;
          none_valid <= ~|mask;
          out_valid <= 1'b1;
        end
        RESULT: if (out_ready) begin
          st <= IDLE;
          out_valid <= 1'b0;
          busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sad_stream_modesel.sv
// tb_sad_stream_modesel: randomized + directed self-checking bench against an arithmetic SAD/argmin model
module tb_sad_stream_modesel;
  localparam int NB = 16;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, out_ready = 1, busy;
  logic [3:0] mode_mask = '0;
  logic signed [3:0][3:0][8:0] res = '0;
  logic in_ready, none_valid, out_valid;
  logic [3:0][14:0] sads;
  logic [1:0] best_mode;
  logic [14:0] best_sad;
  int checks = 0, failures = 0;
  int rv[NB][4][4];
  int exp_sad[4];
  int exp_bm, exp_bs, exp_nv;

  sad_stream_modesel dut (
    .clk(clk), .reset(reset), .start(start), .mode_mask(mode_mask), .res(res),
    .in_valid(in_valid), .in_ready(in_ready), .sads(sads), .best_mode(best_mode),
    .best_sad(best_sad), .none_valid(none_valid), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_const(input int a0, input int a1, input int a2, input int a3);
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < 4; l++) begin
        rv[b][0][l] = a0; rv[b][1][l] = a1; rv[b][2][l] = a2; rv[b][3][l] = a3;
      end
  endtask

  task automatic fill_rand();
    for (int b = 0; b < NB; b++)
      for (int m = 0; m < 4; m++)
        for (int l = 0; l < 4; l++) rv[b][m][l] = int'($urandom_range(0, 511)) - 256;
  endtask

  task automatic model(input logic [3:0] mk);
    int q[$];
    int mn[$];
    for (int m = 0; m < 4; m++) begin
      exp_sad[m] = 0;
      for (int b = 0; b < NB; b++)
        for (int l = 0; l < 4; l++)
          exp_sad[m] += (rv[b][m][l] < 0) ? -rv[b][m][l] : rv[b][m][l];
      if (mk[m]) q.push_back(exp_sad[m]);
    end
    exp_bm = 0;
    if (q.size() == 0) begin
      exp_bs = 32767;
      exp_nv = 1;
    end else begin
      mn = q.min();
      exp_bs = mn[0];
      exp_nv = 0;
      for (int m = 3; m >= 0; m--) if (mk[m] && exp_sad[m] == exp_bs) exp_bm = m;
    end
  endtask

  task automatic drive_beat(input int b);
    for (int m = 0; m < 4; m++)
      for (int l = 0; l < 4; l++) res[m][l] = 9'(rv[b][m][l]);
  endtask

  task automatic run_block(input logic [3:0] mk, input bit gap, input int hold);
    int b, cyc, lat;
    bit acc;
    model(mk);
    out_ready = (hold == 0);
    @(negedge clk); start = 1; mode_mask = mk;
    @(negedge clk); start = 0; mode_mask = '0;
    chk("in_ready_rise", in_ready, 1);
    b = 0; cyc = 0;
    while (b < NB && cyc < 4 * NB) begin
      in_valid = !gap || (cyc % 2 == 0);
      drive_beat(b);
      if (!in_valid) chk("in_ready_gap", in_ready, 1);
      acc = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) b++;
    end
    chk("beats_done", b, NB);
    in_valid = 1;
    res = '1;
    chk("in_ready_fall", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
    in_valid = 0;
    res = '0;
    chk("latency", lat, 2);
    for (int m = 0; m < 4; m++) chk($sformatf("sads%0d", m), sads[m], exp_sad[m]);
    chk("best_mode", best_mode, exp_bm);
    chk("best_sad", best_sad, exp_bs);
    chk("none_valid", none_valid, exp_nv);
    for (int i = 0; i < hold; i++) begin
      start = (i == 2);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_sad", best_sad, exp_bs);
      chk("hold_sads0", sads[0], exp_sad[0]);
    end
    start = 0;
    out_ready = 1;
    @(negedge clk);
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    if (hold > 0) begin
      @(negedge clk);
      chk("start_ignored", busy, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sads", sads, 0);
    chk("rst_best_mode", best_mode, 0);
    chk("rst_best_sad", best_sad, 0);
    chk("rst_none_valid", none_valid, 0);
    reset = 0;
    @(negedge clk);
    fill_const(1, -2, 0, 3);
    run_block(4'b1111, 0, 0);
    fill_const(-256, 1, 1, 1);
    run_block(4'b0001, 0, 0);
    fill_const(0, 0, 0, 0);
    rv[0][0][0] = 50; rv[3][1][2] = -50; rv[5][2][1] = 10; rv[9][3][3] = -60;
    run_block(4'b1011, 0, 0);
    fill_rand();
    run_block(4'b0000, 0, 0);
    fill_rand();
    run_block(4'b1111, 0, 0);
    run_block(4'b1111, 1, 0);
    run_block(4'b0110, 0, 5);
    for (int k = 0; k < 4; k++) begin
      fill_rand();
      run_block(4'($urandom_range(0, 15)), k[0], 0);
    end
    fill_rand();
    @(negedge clk); start = 1; mode_mask = 4'b1111;
    @(negedge clk); start = 0;
    in_valid = 1;
    for (int b = 0; b < 7; b++) begin drive_beat(b); @(negedge clk); end
    #2 reset = 1;
    #1;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_sads", sads, 0);
    in_valid = 0;
    @(negedge clk); reset = 0;
    fill_const(1, 1, 1, 1);
    run_block(4'b1111, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
